// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_lock_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int IDX_WIDTH = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]   request;
   logic [NUM_REQ-1:0]   lock;
   logic                 grant_ack;
   logic                 grant_valid;
   logic [NUM_REQ-1:0]   grant_oh;
   logic [IDX_WIDTH-1:0] grant_idx;
   logic                 busy;

   modport master (
      output request, lock, grant_ack,
      input  grant_valid, grant_oh, grant_idx, busy
   );

   modport slave (
      input  request, lock, grant_ack,
      output grant_valid, grant_oh, grant_idx, busy
   );
endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a registered grant that is held until accepted,
// plus bounded lock bursts that keep one requester granted across accepts.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no grant presented; arbitrate from ptr when any request
// ST_GRANTED | grant presented; hold until accept (lock or release) or cancel
module rr_lock_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int IDX_WIDTH = $clog2(NUM_REQ),
   parameter int LOCK_MAX  = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   rr_lock_arbiter_if.slave arb_if
);
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W:0] LOCK_LIM = LOCK_MAX[CNT_W:0];

   if (NUM_REQ < 2) begin : g_bad_num_req
      $error("rr_lock_arbiter: NUM_REQ must be at least 2");
   end
   if (LOCK_MAX < 1) begin : g_bad_lock_max
      $error("rr_lock_arbiter: LOCK_MAX must be at least 1");
   end

   typedef enum logic {ST_IDLE = 1'b0, ST_GRANTED = 1'b1} state_t;

   state_t               state_q;
   logic [NUM_REQ-1:0]   grant_oh_q;
   logic [IDX_WIDTH-1:0] grant_idx_q;
   logic [IDX_WIDTH-1:0] ptr_q;
   logic [IDX_WIDTH-1:0] ptr_d;
   logic [CNT_W-1:0]     lock_cnt_q;

   logic                 req_held;
   logic                 lock_held;
   logic                 lock_cont;
   logic                 scan_found;
   logic [IDX_WIDTH-1:0] scan_idx;
   logic                 rel_found;
   logic [IDX_WIDTH-1:0] rel_idx;

   // First set bit of req scanning start, start+1, ... wrapping at NUM_REQ.
   function automatic logic [IDX_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0]   req,
                                                  input logic [IDX_WIDTH-1:0] start);
      logic                 found;
      logic [IDX_WIDTH-1:0] idx;
      int                   pos;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = int'(start) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = IDX_WIDTH'(pos);
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [NUM_REQ-1:0] to_oh(input logic [IDX_WIDTH-1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // Arbitration candidates: scan from ptr (idle / cancel, holder excluded)
   // and scan from the slot after the holder (release).
   always_comb begin
      req_held  = |(arb_if.request & grant_oh_q);
      lock_held = |(arb_if.lock & grant_oh_q);
      lock_cont = lock_held && req_held && (({1'b0, lock_cnt_q} + 1'b1) < LOCK_LIM);
      ptr_d     = (grant_idx_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
      {scan_found, scan_idx} = rr_pick(arb_if.request & ~grant_oh_q, ptr_q);
      {rel_found, rel_idx}   = rr_pick(arb_if.request, ptr_d);
   end

   // Grant FSM: present, hold, lock-continue, release or cancel.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         grant_oh_q  <= '0;
         grant_idx_q <= '0;
         ptr_q       <= '0;
         lock_cnt_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               lock_cnt_q <= '0;
               if (scan_found) begin
                  state_q     <= ST_GRANTED;
                  grant_idx_q <= scan_idx;
                  grant_oh_q  <= to_oh(scan_idx);
               end
            end
            ST_GRANTED: begin
               if (arb_if.grant_ack) begin
                  if (lock_cont) begin
                     lock_cnt_q <= lock_cnt_q + 1'b1;
                  end else begin
                     ptr_q      <= ptr_d;
                     lock_cnt_q <= '0;
                     if (rel_found) begin
                        grant_idx_q <= rel_idx;
                        grant_oh_q  <= to_oh(rel_idx);
                     end else begin
                        state_q     <= ST_IDLE;
                        grant_idx_q <= '0;
                        grant_oh_q  <= '0;
                     end
                  end
               end else if (!req_held) begin
                  // Cancel: requester withdrew before the accept.
                  lock_cnt_q <= '0;
                  if (scan_found) begin
                     grant_idx_q <= scan_idx;
                     grant_oh_q  <= to_oh(scan_idx);
                  end else begin
                     state_q     <= ST_IDLE;
                     grant_idx_q <= '0;
                     grant_oh_q  <= '0;
                  end
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               grant_idx_q <= '0;
               grant_oh_q  <= '0;
               lock_cnt_q  <= '0;
            end
         endcase
      end
   end

   assign arb_if.grant_valid = (state_q == ST_GRANTED);
   assign arb_if.grant_oh    = grant_oh_q;
   assign arb_if.grant_idx   = grant_idx_q;
   assign arb_if.busy        = (state_q == ST_GRANTED) || (lock_cnt_q != '0);
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: a 4-requester and a 3-requester instance share
// one stimulus stream and are compared every cycle against a distance-based
// round-robin reference model.
module tb_rr_lock_arbiter;
   localparam int LOCK_MAX = 4;

   logic       clk = 1'b0;
   logic       rst_s = 1'b1;
   logic [3:0] req_s = '0;
   logic [3:0] lock_s = '0;
   logic       ack_s = 1'b0;

   int err_cnt = 0;
   int chk_cnt = 0;

   int m_valid [2];
   int m_idx   [2];
   int m_ptr   [2];
   int m_cnt   [2];

   always #5 clk = ~clk;

   rr_lock_arbiter_if #(.NUM_REQ(4), .IDX_WIDTH(2)) bus4 ();
   rr_lock_arbiter_if #(.NUM_REQ(3), .IDX_WIDTH(2)) bus3 ();

   assign bus4.request   = req_s;
   assign bus4.lock      = lock_s;
   assign bus4.grant_ack = ack_s;
   assign bus3.request   = req_s[2:0];
   assign bus3.lock      = lock_s[2:0];
   assign bus3.grant_ack = ack_s;

   rr_lock_arbiter #(.NUM_REQ(4), .IDX_WIDTH(2), .LOCK_MAX(LOCK_MAX)) dut4 (
      .clk_i   (clk),
      .reset_i (rst_s),
      .arb_if  (bus4)
   );

   rr_lock_arbiter #(.NUM_REQ(3), .IDX_WIDTH(2), .LOCK_MAX(LOCK_MAX)) dut3 (
      .clk_i   (clk),
      .reset_i (rst_s),
      .arb_if  (bus3)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Requester closest (in round-robin distance) to p, ignoring excl.
   function automatic int model_pick(input logic [3:0] r, input int p, input int n, input int excl);
      int best;
      int best_d;
      int d;
      best   = -1;
      best_d = n;
      for (int i = 0; i < n; i++) begin
         if (r[i] && i != excl) begin
            d = (i - p + n) % n;
            if (d < best_d) begin
               best_d = d;
               best   = i;
            end
         end
      end
      return best;
   endfunction

   task automatic model_step(input int k, input int n, input logic [3:0] r,
                             input logic [3:0] l, input logic a, input logic rs);
      int w;
      if (rs) begin
         m_valid[k] = 0;
         m_idx[k]   = 0;
         m_ptr[k]   = 0;
         m_cnt[k]   = 0;
      end else if (m_valid[k] == 0) begin
         w = model_pick(r, m_ptr[k], n, -1);
         if (w >= 0) begin
            m_valid[k] = 1;
            m_idx[k]   = w;
         end
      end else if (a) begin
         if (l[m_idx[k]] && r[m_idx[k]] && (m_cnt[k] + 1 < LOCK_MAX)) begin
            m_cnt[k]++;
         end else begin
            m_ptr[k] = (m_idx[k] + 1) % n;
            m_cnt[k] = 0;
            w = model_pick(r, m_ptr[k], n, -1);
            if (w >= 0) m_idx[k] = w;
            else m_valid[k] = 0;
         end
      end else if (!r[m_idx[k]]) begin
         m_cnt[k] = 0;
         w = model_pick(r, m_ptr[k], n, m_idx[k]);
         if (w >= 0) m_idx[k] = w;
         else m_valid[k] = 0;
      end
   endtask

   task automatic compare_all();
      logic [3:0] exp_oh4;
      logic [2:0] exp_oh3;
      exp_oh4 = '0;
      exp_oh3 = '0;
      if (m_valid[0] != 0) exp_oh4[m_idx[0]] = 1'b1;
      if (m_valid[1] != 0) exp_oh3[m_idx[1]] = 1'b1;
      check_val("valid4", 32'(bus4.grant_valid), 32'(m_valid[0]));
      check_val("oh4", 32'(bus4.grant_oh), 32'(exp_oh4));
      if (m_valid[0] != 0) check_val("idx4", 32'(bus4.grant_idx), 32'(m_idx[0]));
      check_val("busy4", 32'(bus4.busy), 32'(m_valid[0] != 0 || m_cnt[0] != 0));
      check_val("valid3", 32'(bus3.grant_valid), 32'(m_valid[1]));
      check_val("oh3", 32'(bus3.grant_oh), 32'(exp_oh3));
      if (m_valid[1] != 0) check_val("idx3", 32'(bus3.grant_idx), 32'(m_idx[1]));
      check_val("busy3", 32'(bus3.busy), 32'(m_valid[1] != 0 || m_cnt[1] != 0));
      check_val("idx3_range", 32'(bus3.grant_idx != 2'd3), 32'd1);
   endtask

   // Apply one cycle of stimulus, advance the model, then compare after the edge.
   task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic a, input logic rs);
      req_s  = r;
      lock_s = l;
      ack_s  = a;
      rst_s  = rs;
      model_step(0, 4, r, l, a, rs);
      model_step(1, 3, r & 4'b0111, l & 4'b0111, a, rs);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      logic [3:0] r;
      logic [3:0] l;
      logic       a;
      logic       rs;
      int         exp_seq [5];

      // 1: basic grant, ack, wrap
      cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
      check_val("t1_reset_idx", 32'(bus4.grant_idx), 32'd0);
      check_val("t1_reset_busy", 32'(bus4.busy), 32'd0);
      cycle(4'b1010, 4'b0000, 1'b0, 1'b0);
      check_val("t1_first", 32'(bus4.grant_idx), 32'd1);
      check_val("t1_first_oh", 32'(bus4.grant_oh), 32'h2);
      cycle(4'b1010, 4'b0000, 1'b1, 1'b0);
      check_val("t1_second", 32'(bus4.grant_idx), 32'd3);
      cycle(4'b1010, 4'b0000, 1'b1, 1'b0);
      check_val("t1_wrap", 32'(bus4.grant_idx), 32'd1);

      // 2: all requesting, ack every cycle, no bubbles
      cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
      exp_seq = '{0, 1, 2, 3, 0};
      cycle(4'b1111, 4'b0000, 1'b0, 1'b0);
      check_val("t2_idx", 32'(bus4.grant_idx), 32'(exp_seq[0]));
      for (int i = 1; i < 5; i++) begin
         cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
         check_val("t2_idx", 32'(bus4.grant_idx), 32'(exp_seq[i]));
         check_val("t2_nobubble", 32'(bus4.grant_valid), 32'd1);
      end

      // 3: lock burst of LOCK_MAX accepts, then forced release
      cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
      cycle(4'b0101, 4'b0001, 1'b0, 1'b0);
      check_val("t3_first", 32'(bus4.grant_idx), 32'd0);
      for (int i = 0; i < LOCK_MAX - 1; i++) begin
         cycle(4'b0101, 4'b0001, 1'b1, 1'b0);
         check_val("t3_locked", 32'(bus4.grant_idx), 32'd0);
         check_val("t3_busy", 32'(bus4.busy), 32'd1);
      end
      cycle(4'b0101, 4'b0001, 1'b1, 1'b0);
      check_val("t3_forced", 32'(bus4.grant_idx), 32'd2);
      cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
      check_val("t3_idle_busy", 32'(bus4.busy), 32'd0);

      // 4: cancel to another requester, then cancel to nothing
      cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
      cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
      check_val("t4_grant2", 32'(bus4.grant_idx), 32'd2);
      cycle(4'b1000, 4'b0000, 1'b0, 1'b0);
      check_val("t4_cancel_to3", 32'(bus4.grant_idx), 32'd3);
      cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
      cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
      cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
      check_val("t4_cancel_valid", 32'(bus4.grant_valid), 32'd0);
      check_val("t4_cancel_oh", 32'(bus4.grant_oh), 32'd0);

      // 5: hold without ack, reset mid-grant, pointer back at 0
      cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
      cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
      cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
         check_val("t5_hold", 32'(bus4.grant_oh), 32'h2);
      end
      cycle(4'b0010, 4'b0000, 1'b1, 1'b1);
      check_val("t5_rst_valid", 32'(bus4.grant_valid), 32'd0);
      check_val("t5_rst_oh", 32'(bus4.grant_oh), 32'd0);
      cycle(4'b0110, 4'b0000, 1'b0, 1'b0);
      check_val("t5_ptr0", 32'(bus4.grant_idx), 32'd1);

      // 6: three-requester rotation
      cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
      exp_seq = '{0, 1, 2, 0, 1};
      cycle(4'b0111, 4'b0000, 1'b0, 1'b0);
      check_val("t6_idx", 32'(bus3.grant_idx), 32'(exp_seq[0]));
      for (int i = 1; i < 4; i++) begin
         cycle(4'b0111, 4'b0000, 1'b1, 1'b0);
         check_val("t6_idx", 32'(bus3.grant_idx), 32'(exp_seq[i]));
      end

      // Random phase: sticky requests/locks, frequent acks, rare resets.
      r = 4'b0000;
      l = 4'b0000;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(7) == 0) r[b] = ~r[b];
            if ($urandom_range(5) == 0) l[b] = ~l[b];
         end
         a  = ($urandom_range(3) != 0);
         rs = ($urandom_range(199) == 0);
         cycle(r, l, a, rs);
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among NUM_REQ requesters, such as a thread-select slot or a shared port.
- Produces a registered grant as both a one-hot vector and a binary index.
- Holds the grant stable until the downstream accepts it.
- Supports bounded lock bursts, where one requester keeps the grant across consecutive accepts, up to LOCK_MAX.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- IDX_WIDTH, $clog2(NUM_REQ) (2), width of the grant index.
- LOCK_MAX, 4, maximum consecutive accepted grants to one locked requester before a forced release; must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- request  input  NUM_REQ  per-requester request; level held until served.
- lock  input  NUM_REQ  per-requester lock hint; sampled only on the accept cycle.
- grant_ack  input  1  downstream accepts the current grant this cycle; ignored when grant_valid=0.
- grant_valid  output  1  a grant is presented.
- grant_oh  output  NUM_REQ  one-hot grant; all zeros when grant_valid=0.
- grant_idx  output  IDX_WIDTH  binary index of the granted requester; equals the decode of grant_oh when valid.
- busy  output  1  high while grant_valid or a lock burst is active.

Behaviour:
- Reset values (synchronous): grant_valid=0, grant_oh=0, grant_idx=0, busy=0. Priority pointer ptr=0, so requester 0 has highest priority. Lock counter lock_cnt=0.
- Reset asserted mid-grant drops the grant on the next edge regardless of grant_ack.
- Arbitration function (combinational):
  - The winner is the first set bit of request, scanning ptr, ptr+1, … modulo NUM_REQ.
  - None is found if request==0.
- State IDLE (grant_valid=0):
  - If request!=0 in cycle n, the registered grant appears in cycle n+1: grant_valid=1, grant_oh/grant_idx=winner.
  - Latency from request to grant is 1 cycle.
- State GRANTED, no grant_ack:
  - grant_oh, grant_idx and ptr stay stable while request[grant_idx]=1.
  - If request[grant_idx] drops without an ack, this is a cancel:
    - Next cycle re-arbitrates from the current ptr.
    - The cancelled requester is excluded for that one arbitration.
    - grant_valid=1 if another request is pending, else 0.
    - lock_cnt is cleared.
- State GRANTED, grant_ack=1 in cycle n (accept):
  - Locked continue condition: lock[grant_idx]=1 and request[grant_idx]=1 and lock_cnt+1 < LOCK_MAX.
    - Same grant held in cycle n+1.
    - lock_cnt increments.
    - ptr is unchanged.
  - Otherwise (release):
    - ptr := (grant_idx+1) mod NUM_REQ.
    - lock_cnt := 0.
    - Winner is computed with the new ptr from cycle-n request and registered for n+1.
    - Back-to-back grants have no bubble.
    - The previous holder can win again only if it is the sole requester.
  - Forced release: when lock_cnt+1 reaches LOCK_MAX, release is mandatory even if lock is held. This bounds starvation.
- Wrap-around: ptr and the index scan wrap modulo NUM_REQ. For non-power-of-2 NUM_REQ, indexes ≥ NUM_REQ are never produced.
- Invariants (assertion-checked):
  - At most one bit of grant_oh is set.
  - grant_oh==0 iff grant_valid==0.
  - A grant is never issued to a requester whose request bit was 0 in the arbitration cycle.
- busy = grant_valid | (lock_cnt!=0).
- Simultaneous events: grant_ack together with a drop of request[grant_idx] counts as an accept (the grant is consumed), then release.

Test Plan:
1. Reset, then request=4'b1010 in cycle 1 → cycle 2: grant_valid=1, grant_idx=1, grant_oh=0010. Ack in cycle 2 → cycle 3: grant_idx=3. Ack in cycle 3 → cycle 4: grant_idx=1 (wrap, ptr=0).
2. request=4'b1111 held, ack every cycle → grants 0,1,2,3,0 on consecutive cycles, grant_valid never drops, no bubbles.
3. request=4'b0101, lock[0]=1 held, ack every cycle, LOCK_MAX=4 → grant_idx=0 for 4 consecutive accepts, then forced release to 2. lock_cnt returns to 0 and busy tracks it.
4. Grant to idx 2 with no ack, then request[2] drops while request[3]=1 → next cycle grant_idx=3. With request=0 instead → grant_valid=0, grant_oh=0.
5. Grant held 5 cycles without ack, request stable → grant_oh/grant_idx unchanged every cycle. Assert reset in cycle 3 → cycle 4: grant_valid=0, grant_oh=0, ptr=0.
6. NUM_REQ=3 instance, request=3'b111, ack each cycle → grant_idx cycles 0,1,2,0. The value 3 is never produced, and grant_oh always equals the decode of grant_idx.
